mor1kx_bus_if_wb_burst: RTL

//  Parametrised Wishbone B3 master bridge between a mor1kx fetch/LSU port and the system bus.

---
 rtl/mor1kx_bus_if_wb_burst_pkg.sv | 30 +++
 rtl/mor1kx_wb_burst_adr_gen.sv | 39 +++
 rtl/mor1kx_bus_if_wb_burst.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mor1kx_bus_if_wb_burst_pkg.sv
// Shared encodings for the mor1kx Wishbone burst bridge: FSM states, CTI and BTE codes.
package mor1kx_bus_if_wb_burst_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSingle,
        StBurst,
        StEnd,
        StRetry
    } state_e;

    localparam logic [2:0] CtiClassic = 3'b000;
    localparam logic [2:0] CtiIncr    = 3'b010;
    localparam logic [2:0] CtiEnd     = 3'b111;

    localparam logic [1:0] BteLinear = 2'b00;
    localparam logic [1:0] BteWrap4  = 2'b01;
    localparam logic [1:0] BteWrap8  = 2'b10;
    localparam logic [1:0] BteWrap16 = 2'b11;

    function automatic logic [1:0] bte_for(input int unsigned burst_length);
        case (burst_length)
            4:       return BteWrap4;
            8:       return BteWrap8;
            16:      return BteWrap16;
            default: return BteLinear;
        endcase
    endfunction

endpackage

// File: rtl/mor1kx_wb_burst_adr_gen.sv
// Wrap-burst address stepper: next beat address and whether that beat closes the wrap.
module mor1kx_wb_burst_adr_gen #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned BURST_LENGTH = 8
) (
    input  logic [ADDR_WIDTH-1:0] cur_adr_i,
    input  logic [ADDR_WIDTH-1:0] start_adr_i,
    output logic [ADDR_WIDTH-1:0] next_adr_o,
    output logic                  next_last_o
);

    localparam int unsigned OffW = $clog2(DATA_WIDTH / 8);

    if (BURST_LENGTH == 0) begin : g_linear
        assign next_adr_o  = cur_adr_i + ADDR_WIDTH'(DATA_WIDTH / 8);
        assign next_last_o = 1'b0;
    end else begin : g_wrap
        localparam int unsigned IdxW = $clog2(BURST_LENGTH);

        logic [IdxW-1:0]       next_idx;
        logic [IdxW-1:0]       last_idx;
        logic [ADDR_WIDTH-1:0] last_adr;

        assign next_idx = cur_adr_i[OffW +: IdxW] + IdxW'(1);
        assign last_idx = start_adr_i[OffW +: IdxW] - IdxW'(1);

        // Only the wrap field moves; upper and byte-offset bits are held.
        always_comb begin
            next_adr_o                 = cur_adr_i;
            next_adr_o[OffW +: IdxW]   = next_idx;
            last_adr                   = start_adr_i;
            last_adr[OffW +: IdxW]     = last_idx;
        end

        assign next_last_o = (next_adr_o == last_adr);
    end

endmodule

// File: rtl/mor1kx_bus_if_wb_burst.sv
// Wishbone B3 master bridge for a mor1kx CPU port with wrap bursts, abort and bounded retry.
// Optional beat watchdog enabled by defining MOR1KX_BUS_IF_TIMEOUT_EN.
module mor1kx_bus_if_wb_burst
    import mor1kx_bus_if_wb_burst_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned BURST_LENGTH = 8,
    parameter int unsigned RETRY_MAX    = 3,
    parameter int unsigned TIMEOUT_CYC  = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   cpu_adr_i,
    input  logic [DATA_WIDTH-1:0]   cpu_dat_i,
    input  logic                    cpu_req_i,
    input  logic [DATA_WIDTH/8-1:0] cpu_bsel_i,
    input  logic                    cpu_we_i,
    input  logic                    cpu_burst_i,
    output logic                    cpu_ack_o,
    output logic                    cpu_err_o,
    output logic [DATA_WIDTH-1:0]   cpu_dat_o,
    output logic [ADDR_WIDTH-1:0]   wbm_adr_o,
    output logic [DATA_WIDTH-1:0]   wbm_dat_o,
    output logic [DATA_WIDTH/8-1:0] wbm_sel_o,
    output logic                    wbm_we_o,
    output logic                    wbm_cyc_o,
    output logic                    wbm_stb_o,
    output logic [2:0]              wbm_cti_o,
    output logic [1:0]              wbm_bte_o,
    input  logic                    wbm_ack_i,
    input  logic                    wbm_err_i,
    input  logic                    wbm_rty_i,
    input  logic [DATA_WIDTH-1:0]   wbm_dat_i
);

    localparam int unsigned RtyW     = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
    localparam logic [1:0]  BurstBte = bte_for(BURST_LENGTH);

    state_e                    state_q, ret_state_q;
    logic [ADDR_WIDTH-1:0]     adr_q, start_q, next_adr;
    logic [DATA_WIDTH-1:0]     dat_q;
    logic [DATA_WIDTH/8-1:0]   sel_q;
    logic                      we_q, cyc_q, stb_q;
    logic [2:0]                cti_q;
    logic [1:0]                bte_q;
    logic [RtyW-1:0]           retry_cnt_q;
    logic                      next_last;

    logic active, adr_match, go_burst, abort;
    logic term_err, term_ack, term_rty, rty_limit, tmo_hit;

    mor1kx_wb_burst_adr_gen #(
        .DATA_WIDTH   (DATA_WIDTH),
        .ADDR_WIDTH   (ADDR_WIDTH),
        .BURST_LENGTH (BURST_LENGTH)
    ) u_adr_gen (
        .cur_adr_i   (adr_q),
        .start_adr_i (start_q),
        .next_adr_o  (next_adr),
        .next_last_o (next_last)
    );

    // Terminations only count for beats the CPU still owns; END beats are drained silently.
    assign active    = cyc_q & stb_q & ((state_q == StSingle) | (state_q == StBurst));
    assign adr_match = cpu_req_i & (cpu_adr_i == adr_q);
    assign go_burst  = !cpu_we_i & cpu_burst_i & (BURST_LENGTH != 0);
    assign abort     = (state_q == StBurst) & !adr_match;

    assign term_err  = active & wbm_err_i;
    assign term_ack  = active & !wbm_err_i & wbm_ack_i;
    assign term_rty  = active & !wbm_err_i & !wbm_ack_i & wbm_rty_i;
    assign rty_limit = term_rty & (retry_cnt_q == RtyW'(RETRY_MAX));

    assign cpu_ack_o = term_ack & adr_match;
    assign cpu_err_o = term_err | rty_limit | tmo_hit;
    assign cpu_dat_o = (active & !wbm_err_i) ? wbm_dat_i : '0;

`ifdef MOR1KX_BUS_IF_TIMEOUT_EN
    localparam int unsigned TmoRaw = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned TmoW   = (TmoRaw < 8) ? 8 : ((TmoRaw > 16) ? 16 : TmoRaw);

    logic [TmoW-1:0] tmo_cnt_q;
    logic            tmo_quiet;

    assign tmo_quiet = cyc_q & stb_q & !wbm_ack_i & !wbm_err_i & !wbm_rty_i;
    assign tmo_hit   = tmo_quiet & (tmo_cnt_q == TmoW'(TIMEOUT_CYC - 1));

    // Cleared while stb is low, so every stb rise restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
        end else if (!tmo_quiet) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            ret_state_q <= StSingle;
            adr_q       <= '0;
            start_q     <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            we_q        <= 1'b0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            cti_q       <= CtiClassic;
            bte_q       <= BteLinear;
            retry_cnt_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    retry_cnt_q <= '0;
                    if (cpu_req_i) begin
                        adr_q   <= cpu_adr_i;
                        start_q <= cpu_adr_i;
                        dat_q   <= cpu_dat_i;
                        sel_q   <= cpu_bsel_i;
                        we_q    <= cpu_we_i;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        if (go_burst) begin
                            state_q <= StBurst;
                            cti_q   <= CtiIncr;
                            bte_q   <= BurstBte;
                        end else begin
                            state_q <= StSingle;
                            cti_q   <= CtiClassic;
                            bte_q   <= BteLinear;
                        end
                    end
                end
                StSingle, StBurst: begin
                    if (term_err || rty_limit || tmo_hit) begin
                        state_q <= StIdle;
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        cti_q   <= CtiClassic;
                        bte_q   <= BteLinear;
                    end else if (term_rty) begin
                        state_q     <= StRetry;
                        ret_state_q <= state_q;
                        cyc_q       <= 1'b0;
                        stb_q       <= 1'b0;
                        retry_cnt_q <= retry_cnt_q + RtyW'(1);
                    end else if (term_ack) begin
                        retry_cnt_q <= '0;
                        if (state_q == StSingle || cti_q == CtiEnd) begin
                            state_q <= StIdle;
                            cyc_q   <= 1'b0;
                            stb_q   <= 1'b0;
                            cti_q   <= CtiClassic;
                            bte_q   <= BteLinear;
                        end else begin
                            adr_q <= next_adr;
                            // A beat acked after the CPU walked away still forces one END beat.
                            if (abort) begin
                                cti_q   <= CtiEnd;
                                state_q <= StEnd;
                            end else begin
                                cti_q <= next_last ? CtiEnd : CtiIncr;
                            end
                        end
                    end else if (abort && cti_q != CtiEnd) begin
                        cti_q   <= CtiEnd;
                        state_q <= StEnd;
                    end
                end
                StEnd: begin
                    if (wbm_ack_i || wbm_err_i || wbm_rty_i || tmo_hit) begin
                        state_q <= StIdle;
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        cti_q   <= CtiClassic;
                        bte_q   <= BteLinear;
                    end
                end
                StRetry: begin
                    state_q <= ret_state_q;
                    cyc_q   <= 1'b1;
                    stb_q   <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                    cyc_q   <= 1'b0;
                    stb_q   <= 1'b0;
                end
            endcase
        end
    end

    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign wbm_sel_o = sel_q;
    assign wbm_we_o  = we_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = stb_q;
    assign wbm_cti_o = cti_q;
    assign wbm_bte_o = bte_q;

endmodule
